disk_block_xfer: RTL
====================

# disk_block_xfer

Single-block disk transfer sequencer between the PDP-8 disk IOT controller and the IDE block engine. It owns the 256×12 sector buffer and moves one 256-word block between main memory and that buffer over a DMA handshake. It also drives the IDE engine's read/write request lines and serves the engine's buffer port. Read sequence: disk → buffer → memory. Write sequence: memory → buffer → disk.

## Interface
Parameters:
- FIELD_W, 3, memory field bits; full DMA address width is FIELD_W+12.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cmd_read  in  1  one-cycle request: read block from disk into memory
- cmd_write  in  1  one-cycle request: write block from memory to disk
- cmd_lba  in  24  block number; sampled on accept
- cmd_addr  in  FIELD_W+12  first memory address; sampled on accept
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- error  out  1  sticky command-rejected flag
- ide_lba  out  24  latched cmd_lba
- ide_read_req  out  1  held high for the whole disk phase of a read
- ide_write_req  out  1  held high for the whole disk phase of a write
- ide_done  in  1  one-cycle pulse from the IDE engine at end of sector
- buffer_addr  in  8  IDE engine buffer word address
- buffer_rd  in  1  IDE engine buffer read strobe (informational)
- buffer_wr  in  1  IDE engine buffer write strobe
- buffer_out  in  12  data from disk into buffer
- buffer_in  out  12  data from buffer to disk
- dma_req  out  1  memory cycle request
- dma_write  out  1  1 = store to memory, 0 = fetch
- dma_addr  out  FIELD_W+12  memory address
- dma_wdata  out  12  store data
- dma_rdata  in  12  fetch data; valid in the dma_ack cycle
- dma_ack  in  1  memory cycle complete

## Operation
- Buffer: 256×12 RAM with asynchronous read and synchronous write.
  - Disk port: buffer_in = buf[buffer_addr] combinationally, valid the same cycle the engine samples it. On a clk edge with buffer_wr, buf[buffer_addr] <= buffer_out.
  - DMA port: uses word counter wc[7:0].
- States: IDLE, FILL, DISK, DRAIN, FIN.
- IDLE: exactly one of cmd_read/cmd_write high → accept.
  - Latch lba, addr, direction; wc <= 0; clear error.
  - Next state: FILL for a write, DISK for a read.
  - Both high → reject: error <= 1, stay IDLE.
- Any cmd while busy is ignored and sets error; the current operation continues.
- FILL (write only):
  - dma_req=1, dma_write=0, dma_addr={field, addr12}.
  - On dma_ack: buf[wc] <= dma_rdata, wc++, addr12++.
  - On ack with wc==255 → DISK.
- DISK:
  - ide_read_req or ide_write_req held high per direction until ide_done is seen.
  - Buffer port is owned by the engine; no DMA in this state.
  - On ide_done: read → DRAIN with wc=0, addr12 reloaded from the latched start; write → FIN.
- DRAIN (read only):
  - dma_req=1, dma_write=1, dma_wdata=buf[wc].
  - On dma_ack: wc++, addr12++.
  - On ack with wc==255 → FIN.
- FIN: done=1 for one cycle → IDLE.
- Address arithmetic: addr12 wraps 7777→0000 modulo 4096; field bits never change during a block.
- wc is 8 bits; wrap after word 255 coincides with leaving FILL/DRAIN.

## Timing
- Reset values: busy=0, done=0, error=0, ide_read_req=0, ide_write_req=0, ide_lba=0, dma_req=0, dma_write=0, dma_addr=0, dma_wdata=buf[0]. Buffer contents are not reset.
- busy rises the cycle after accept and is high through FIN; it is low again the cycle after done.
- IDE request asserts the first cycle of DISK and drops the cycle after the ide_done pulse.
- dma_req stays high between back-to-back words. Address and data change the cycle after each ack. With ack every cycle, FILL/DRAIN take 256 cycles.
- Write latency: accept + 256 FILL (min) + disk + 1 FIN. Read latency: accept + disk + 256 DRAIN (min) + 1 FIN.
- Reset mid-operation: all state returns to IDLE next cycle and request lines drop. The IDE engine is reset by the same reset.
- dma_ack while dma_req=0 is ignored. ide_done outside DISK is ignored.

## Test plan
- Read: cmd_read, lba=0x000123, addr=0o17770. IDE model writes buf[i]=i+0o100 via buffer_wr, then pulses ide_done → memory words 0o17770..0o17777 and 0o10000..0o10367 receive 0o100.., the field stays 1, and done pulses once.
- Write: memory preloaded with 0o5000+i at 0o00200, ack every cycle → ide_write_req rises exactly 257 cycles after accept. Engine reads via buffer_addr get buffer_in=0o5000+addr.
- Stalled DMA: ack every 3rd cycle during DRAIN → 256 stores with correct data, no duplicates or skips.
- cmd_read and cmd_write in the same cycle → error=1, busy=0, no IDE request. A following valid cmd clears error.
- cmd_write while busy in DISK → error=1, the original read completes normally, and done pulses once.
- reset asserted in FILL at wc=100 → next cycle busy=0, dma_req=0, ide_*_req=0. A new cmd_read then completes normally.

Source files
------------

// File: rtl/disk_block_xfer_if.sv
// Bus bundle between the disk IOT controller, memory DMA port and IDE block engine.
// "slave" is the transfer sequencer's view; "master" is the surrounding system's view.
interface disk_block_xfer_if #(
    parameter int FIELD_W = 3
);
    logic                 cmd_read;
    logic                 cmd_write;
    logic [23:0]          cmd_lba;
    logic [FIELD_W+11:0]  cmd_addr;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [23:0]          ide_lba;
    logic                 ide_read_req;
    logic                 ide_write_req;
    logic                 ide_done;
    logic [7:0]           buffer_addr;
    logic                 buffer_rd;
    logic                 buffer_wr;
    logic [11:0]          buffer_out;
    logic [11:0]          buffer_in;
    logic                 dma_req;
    logic                 dma_write;
    logic [FIELD_W+11:0]  dma_addr;
    logic [11:0]          dma_wdata;
    logic [11:0]          dma_rdata;
    logic                 dma_ack;

    modport slave (
        input  cmd_read, cmd_write, cmd_lba, cmd_addr,
        output busy, done, error,
        output ide_lba, ide_read_req, ide_write_req,
        input  ide_done, buffer_addr, buffer_rd, buffer_wr, buffer_out,
        output buffer_in,
        output dma_req, dma_write, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack
    );

    modport master (
        output cmd_read, cmd_write, cmd_lba, cmd_addr,
        input  busy, done, error,
        input  ide_lba, ide_read_req, ide_write_req,
        output ide_done, buffer_addr, buffer_rd, buffer_wr, buffer_out,
        input  buffer_in,
        input  dma_req, dma_write, dma_addr, dma_wdata,
        output dma_rdata, dma_ack
    );
endinterface

// File: rtl/disk_block_xfer.sv
// Single-block transfer sequencer: owns the 256x12 sector buffer and moves one block
// between main memory (DMA) and the buffer, handing the buffer to the IDE engine in between.
module disk_block_xfer #(
    parameter int FIELD_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    disk_block_xfer_if.slave   bus
);
    localparam int AW = FIELD_W + 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_DISK  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    state_t             state_r;
    logic [11:0]        buf_mem_r [256];
    logic [7:0]         wc_r;
    logic [11:0]        addr12_r;
    logic [11:0]        start12_r;
    logic [FIELD_W-1:0] field_r;
    logic               dir_read_r;
    logic               busy_r;
    logic               done_r;
    logic               error_r;
    logic               ide_read_req_r;
    logic               ide_write_req_r;
    logic [23:0]        ide_lba_r;
    logic               dma_req_r;
    logic               dma_write_r;
    logic [AW-1:0]      dma_addr_r;

    logic               cmd_any_s;
    logic               cmd_one_s;
    logic               ack_s;
    logic               fill_wr_s;
    logic               last_word_s;
    logic [11:0]        addr12_inc_s;
    logic               engine_rd_unused_s;

    // Command decode and DMA handshake qualification.
    always_comb begin
        cmd_any_s    = bus.cmd_read | bus.cmd_write;
        cmd_one_s    = bus.cmd_read ^ bus.cmd_write;
        ack_s        = dma_req_r & bus.dma_ack;
        last_word_s  = (wc_r == 8'd255);
        addr12_inc_s = addr12_r + 12'd1;
        if (state_r == ST_FILL) begin
            fill_wr_s = ack_s;
        end else begin
            fill_wr_s = 1'b0;
        end
    end

    // Sector buffer write port: DMA fill takes priority, engine writes otherwise.
    always_ff @(posedge clk) begin
        if (fill_wr_s) begin
            buf_mem_r[wc_r] <= bus.dma_rdata;
        end else if (bus.buffer_wr) begin
            buf_mem_r[bus.buffer_addr] <= bus.buffer_out;
        end
    end

    // Sequencer: accept, fill, disk handoff, drain, completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            wc_r            <= 8'd0;
            addr12_r        <= 12'd0;
            start12_r       <= 12'd0;
            field_r         <= '0;
            dir_read_r      <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            error_r         <= 1'b0;
            ide_read_req_r  <= 1'b0;
            ide_write_req_r <= 1'b0;
            ide_lba_r       <= 24'd0;
            dma_req_r       <= 1'b0;
            dma_write_r     <= 1'b0;
            dma_addr_r      <= '0;
        end else begin
            done_r <= 1'b0;
            // A command while a block is in flight is refused but never disturbs it.
            if ((state_r != ST_IDLE) && cmd_any_s) begin
                error_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (cmd_one_s) begin
                        ide_lba_r  <= bus.cmd_lba;
                        field_r    <= bus.cmd_addr[AW-1:12];
                        start12_r  <= bus.cmd_addr[11:0];
                        addr12_r   <= bus.cmd_addr[11:0];
                        dir_read_r <= bus.cmd_read;
                        wc_r       <= 8'd0;
                        error_r    <= 1'b0;
                        busy_r     <= 1'b1;
                        if (bus.cmd_read) begin
                            state_r        <= ST_DISK;
                            ide_read_req_r <= 1'b1;
                        end else begin
                            state_r     <= ST_FILL;
                            dma_req_r   <= 1'b1;
                            dma_write_r <= 1'b0;
                            dma_addr_r  <= bus.cmd_addr;
                        end
                    end else if (cmd_any_s) begin
                        error_r <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (ack_s) begin
                        wc_r       <= wc_r + 8'd1;
                        addr12_r   <= addr12_inc_s;
                        dma_addr_r <= {field_r, addr12_inc_s};
                        if (last_word_s) begin
                            state_r         <= ST_DISK;
                            dma_req_r       <= 1'b0;
                            ide_write_req_r <= 1'b1;
                        end
                    end
                end
                ST_DISK: begin
                    if (bus.ide_done) begin
                        ide_read_req_r  <= 1'b0;
                        ide_write_req_r <= 1'b0;
                        if (dir_read_r) begin
                            state_r     <= ST_DRAIN;
                            wc_r        <= 8'd0;
                            addr12_r    <= start12_r;
                            dma_req_r   <= 1'b1;
                            dma_write_r <= 1'b1;
                            dma_addr_r  <= {field_r, start12_r};
                        end else begin
                            state_r <= ST_FIN;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (ack_s) begin
                        wc_r       <= wc_r + 8'd1;
                        addr12_r   <= addr12_inc_s;
                        dma_addr_r <= {field_r, addr12_inc_s};
                        if (last_word_s) begin
                            state_r     <= ST_FIN;
                            dma_req_r   <= 1'b0;
                            dma_write_r <= 1'b0;
                            done_r      <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r         <= ST_IDLE;
                    busy_r          <= 1'b0;
                    ide_read_req_r  <= 1'b0;
                    ide_write_req_r <= 1'b0;
                    dma_req_r       <= 1'b0;
                    dma_write_r     <= 1'b0;
                end
            endcase
        end
    end

    assign engine_rd_unused_s = bus.buffer_rd;

    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.error         = error_r;
    assign bus.ide_lba       = ide_lba_r;
    assign bus.ide_read_req  = ide_read_req_r;
    assign bus.ide_write_req = ide_write_req_r;
    assign bus.dma_req       = dma_req_r;
    assign bus.dma_write     = dma_write_r;
    assign bus.dma_addr      = dma_addr_r;
    // Both read ports are asynchronous so the engine and DMA see data in the same cycle.
    assign bus.buffer_in     = buf_mem_r[bus.buffer_addr];
    assign bus.dma_wdata     = buf_mem_r[wc_r];

endmodule
